// File: rtl/uart_tx_ctrl.sv
// UART transmit control: accepts a word over valid/ready and sequences start/data/parity/stop
// selects for the TX output mux. Define UART_TX_BTB_EN to allow back-to-back frames.
module uart_tx_ctrl #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  data_valid,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic                  data_ready,
    output logic                  busy,
    output logic [1:0]            mux_sel,
    output logic                  ser_out,
    output logic                  parity
);
    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam int PW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);
    localparam logic [PW-1:0] PS_LAST  = PW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                  state_q, state_d;
    logic [PW-1:0]           prescale_q, prescale_d;
    logic [BW-1:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic                    par_en_q, par_en_d;
    logic                    parity_q, parity_d;
    logic                    ser_out_q, ser_out_d;
    logic [1:0]              mux_sel_q, mux_sel_d;
    logic                    busy_q, busy_d;
    logic                    data_ready_q, data_ready_d;
    logic                    accept, bit_end;

    always_comb begin
        state_d    = state_q;
        prescale_d = prescale_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_en_d   = par_en_q;
        parity_d   = parity_q;
        accept     = data_valid && data_ready_q;
        bit_end    = (prescale_q == PS_LAST);

        if (state_q != IDLE)
            prescale_d = bit_end ? '0 : prescale_q + 1'b1;

        case (state_q)
            IDLE:   if (accept) state_d = START;
            START:  if (bit_end) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
            DATA:   if (bit_end) begin
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == BIT_LAST)
                            state_d = par_en_q ? PARITY : STOP;
                    end
            PARITY: if (bit_end) state_d = STOP;
            STOP:   if (bit_end) begin
`ifdef UART_TX_BTB_EN
                        state_d = accept ? START : IDLE;
`else
                        state_d = IDLE;
`endif
                    end
            default: state_d = IDLE;
        endcase

        // data_ready is only ever high in IDLE or the last STOP cycle, so accept implies a new frame
        if (accept) begin
            shift_d    = p_data;
            par_en_d   = par_en;
            parity_d   = par_typ ? ~^p_data : ^p_data;
            bit_cnt_d  = '0;
            prescale_d = '0;
        end

        case (state_d)
            START:   mux_sel_d = 2'b00;
            DATA:    mux_sel_d = 2'b01;
            PARITY:  mux_sel_d = 2'b10;
            default: mux_sel_d = 2'b11;
        endcase
        busy_d       = (state_d != IDLE);
        data_ready_d = (state_d == IDLE);
`ifdef UART_TX_BTB_EN
        data_ready_d = data_ready_d || (state_d == STOP && prescale_d == PS_LAST);
`endif
        // ser_out only tracks the shifter while in DATA and holds elsewhere
        ser_out_d = (state_d == DATA) ? shift_d[0] : ser_out_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            prescale_q   <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_en_q     <= 1'b0;
            parity_q     <= 1'b0;
            ser_out_q    <= 1'b0;
            mux_sel_q    <= 2'b11;
            busy_q       <= 1'b0;
            data_ready_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            prescale_q   <= prescale_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_en_q     <= par_en_d;
            parity_q     <= parity_d;
            ser_out_q    <= ser_out_d;
            mux_sel_q    <= mux_sel_d;
            busy_q       <= busy_d;
            data_ready_q <= data_ready_d;
        end
    end

    assign data_ready = data_ready_q;
    assign busy       = busy_q;
    assign mux_sel    = mux_sel_q;
    assign ser_out    = ser_out_q;
    assign parity     = parity_q;
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: two instances (1 and 4 clocks per bit) checked cycle by cycle
// against a frame model built from the bit list start, data LSB first, parity, stop.
module tb_uart_tx_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] p_data;
    logic [1:0] dv;
    logic       par_en, par_typ;
    logic       rdy1, busy1, ser1, par1, rdy4, busy4, ser4, par4;
    logic [1:0] sel1, sel4;
    int         checks = 0;
    int         errors = 0;

`ifdef UART_TX_BTB_EN
    localparam bit BTB = 1'b1;
`else
    localparam bit BTB = 1'b0;
`endif

    always #5 clk = ~clk;

    uart_tx_ctrl #(.DATA_WIDTH(8), .CLKS_PER_BIT(1)) u1 (
        .clk(clk), .rst(rst), .p_data(p_data), .data_valid(dv[0]), .par_en(par_en),
        .par_typ(par_typ), .data_ready(rdy1), .busy(busy1), .mux_sel(sel1),
        .ser_out(ser1), .parity(par1));

    uart_tx_ctrl #(.DATA_WIDTH(8), .CLKS_PER_BIT(4)) u4 (
        .clk(clk), .rst(rst), .p_data(p_data), .data_valid(dv[1]), .par_en(par_en),
        .par_typ(par_typ), .data_ready(rdy4), .busy(busy4), .mux_sel(sel4),
        .ser_out(ser4), .parity(par4));

    function automatic logic [1:0] g_sel(input int idx);  return idx != 0 ? sel4  : sel1;  endfunction
    function automatic logic       g_busy(input int idx); return idx != 0 ? busy4 : busy1; endfunction
    function automatic logic       g_rdy(input int idx);  return idx != 0 ? rdy4  : rdy1;  endfunction
    function automatic logic       g_ser(input int idx);  return idx != 0 ? ser4  : ser1;  endfunction
    function automatic logic       g_par(input int idx);  return idx != 0 ? par4  : par1;  endfunction

    // Compares every cycle of one frame, starting at the negedge after the accept edge.
    task automatic check_frame(input int idx, input logic [7:0] d, input logic pe, input logic pt,
                               input string tag);
        int         cpb = (idx != 0) ? 4 : 1;
        int         nbits = 10 + int'(pe);
        logic [1:0] exp_sel;
        logic       exp_rdy;
        logic       exp_par = (($countones(d) % 2) == 1) ^ pt;
        for (int b = 0; b < nbits; b++) begin
            for (int c = 0; c < cpb; c++) begin
                exp_sel = (b == 0) ? 2'b00 : (b <= 8) ? 2'b01 : (pe && b == 9) ? 2'b10 : 2'b11;
                exp_rdy = (b == nbits - 1 && c == cpb - 1) ? BTB : 1'b0;
                @(negedge clk);
                checks++;
                if (g_sel(idx) !== exp_sel) begin
                    errors++;
                    $display("FAIL %s mux_sel bit %0d cyc %0d: got %b exp %b", tag, b, c, g_sel(idx), exp_sel);
                end
                checks++;
                if (g_busy(idx) !== 1'b1 || g_rdy(idx) !== exp_rdy) begin
                    errors++;
                    $display("FAIL %s busy/ready bit %0d cyc %0d: got %b/%b exp 1/%b", tag, b, c,
                             g_busy(idx), g_rdy(idx), exp_rdy);
                end
                checks++;
                if (g_par(idx) !== exp_par) begin
                    errors++;
                    $display("FAIL %s parity bit %0d: got %b exp %b", tag, b, g_par(idx), exp_par);
                end
                if (exp_sel == 2'b01) begin
                    checks++;
                    if (g_ser(idx) !== d[b-1]) begin
                        errors++;
                        $display("FAIL %s ser_out data bit %0d: got %b exp %b", tag, b - 1, g_ser(idx), d[b-1]);
                    end
                end
            end
        end
    endtask

    task automatic check_idle(input int idx, input string tag);
        @(negedge clk);
        checks++;
        if (g_sel(idx) !== 2'b11 || g_busy(idx) !== 1'b0 || g_rdy(idx) !== 1'b1) begin
            errors++;
            $display("FAIL %s idle: got sel %b busy %b ready %b exp 11 0 1", tag, g_sel(idx),
                     g_busy(idx), g_rdy(idx));
        end
    endtask

    // Presents one word, waits (bounded) for the accept edge, then scrambles inputs.
    task automatic accept(input int idx, input logic [7:0] d, input logic pe, input logic pt,
                          input string tag);
        int t = 0;
        @(negedge clk);
        p_data = d; par_en = pe; par_typ = pt; dv[idx] = 1'b1;
        while (g_rdy(idx) !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            errors++;
            $display("FAIL %s accept timeout: data_ready stayed %b exp 1", tag, g_rdy(idx));
        end
        @(posedge clk);
        #1;
        dv[idx] = 1'b0; p_data = ~d; par_en = ~pe; par_typ = ~pt;
    endtask

    task automatic test_reset();
        rst = 1'b1; dv = '0; p_data = '0; par_en = 1'b0; par_typ = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (ser1 !== 1'b0 || par1 !== 1'b0 || ser4 !== 1'b0 || par4 !== 1'b0) begin
            errors++;
            $display("FAIL reset ser/par: got %b%b%b%b exp 0000", ser1, par1, ser4, par4);
        end
        repeat (5) begin
            check_idle(0, "reset_u1");
            check_idle(1, "reset_u4");
        end
    endtask

    task automatic test_directed();
        accept(0, 8'hA5, 1'b1, 1'b0, "a5_even");
        check_frame(0, 8'hA5, 1'b1, 1'b0, "a5_even");
        check_idle(0, "a5_even");
        accept(0, 8'h07, 1'b1, 1'b1, "07_odd");
        check_frame(0, 8'h07, 1'b1, 1'b1, "07_odd");
        check_idle(0, "07_odd");
        accept(0, 8'h07, 1'b0, 1'b1, "07_nopar");
        check_frame(0, 8'h07, 1'b0, 1'b1, "07_nopar");
        check_idle(0, "07_nopar");
        accept(1, 8'h01, 1'b0, 1'b0, "cpb4_01");
        check_frame(1, 8'h01, 1'b0, 1'b0, "cpb4_01");
        check_idle(1, "cpb4_01");
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        p_data = 8'h3C; par_en = 1'b1; par_typ = 1'b0; dv[0] = 1'b1;
        @(posedge clk);
        #1;
        p_data = 8'hC3;
        check_frame(0, 8'h3C, 1'b1, 1'b0, "btb_first");
        if (!BTB) check_idle(0, "btb_gap");
        @(posedge clk);
        #1;
        dv[0] = 1'b0;
        check_frame(0, 8'hC3, 1'b1, 1'b0, "btb_second");
        check_idle(0, "btb_second");
    endtask

    task automatic test_reset_mid_frame();
        accept(0, 8'hFF, 1'b0, 1'b0, "rst_mid");
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (sel1 !== 2'b11 || busy1 !== 1'b0 || rdy1 !== 1'b1 || par1 !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid abort: got sel %b busy %b ready %b par %b exp 11 0 1 0",
                     sel1, busy1, rdy1, par1);
        end
        accept(0, 8'h5A, 1'b1, 1'b1, "rst_recover");
        check_frame(0, 8'h5A, 1'b1, 1'b1, "rst_recover");
        check_idle(0, "rst_recover");
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            int         idx = int'($urandom_range(0, 1));
            logic [7:0] d   = 8'($urandom);
            logic       pe  = 1'($urandom);
            logic       pt  = 1'($urandom);
            accept(idx, d, pe, pt, "random");
            check_frame(idx, d, pe, pt, "random");
            check_idle(idx, "random");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
- Upstream control stage of the UART transmitter. Accepts a parallel byte through a valid/ready handshake and serialises it LSB first.
- Computes the parity bit and sequences the frame: start, data, optional parity, stop.
- Drives the 2-bit select, serial data and parity inputs of the downstream TX output multiplexer. Select encoding: 00 = start, 01 = serial data, 10 = parity, 11 = stop/idle.
- The multiplexer's start_bit (0) and end_bit (1) inputs are tied off at the TX top level.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame (1..16).
- CLKS_PER_BIT, 1, clock cycles each frame bit is held (1..65535); 1 means one bit per clock.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- p_data  input  DATA_WIDTH  byte to transmit.
- data_valid  input  1  p_data is valid.
- par_en  input  1  1 = parity bit inserted; sampled at accept.
- par_typ  input  1  0 = even, 1 = odd; sampled at accept.
- data_ready  output  1  block can accept a byte this cycle.
- busy  output  1  frame in progress.
- mux_sel  output  2  select to TX mux.
- ser_out  output  1  current data bit to TX mux.
- parity  output  1  parity bit to TX mux, stable for the whole frame.

Behaviour:
- Reset (rst=1 at clk edge):
  - state=IDLE, mux_sel=11, busy=0, data_ready=1, ser_out=0, parity=0.
  - Bit counter, prescale counter and shift register cleared.
  - Reset mid-frame aborts the frame; the line returns to stop level the next cycle.
- All outputs are registered. data_ready = (state==IDLE) && !rst, registered equivalent.
- Accept: data_valid && data_ready at a clk edge.
  - Latch p_data into the shift register and latch par_en/par_typ.
  - parity = ^p_data when even, ~^p_data when odd, registered at accept.
  - Next cycle: state=START, mux_sel=00, busy=1, data_ready=0.
- data_valid while busy is ignored; no queueing.
- States and transitions; each non-IDLE state holds for CLKS_PER_BIT cycles, counted by the prescale counter:
  - IDLE: mux_sel=11.
  - START: mux_sel=00. Goes to DATA.
  - DATA: mux_sel=01, ser_out = shift_reg[0].
    - At the end of each bit period: shift right, bit counter +1.
    - After DATA_WIDTH bits: go to PARITY if the latched par_en is 1, else STOP.
  - PARITY: mux_sel=10.
  - STOP: mux_sel=11. On its final cycle go to IDLE; busy=0 the following cycle.
- Frame length: (2 + DATA_WIDTH + par_en) × CLKS_PER_BIT cycles, measured from the cycle after accept to the last STOP cycle.
- Minimum IDLE between frames: 1 cycle (without the optional feature).
- Counters:
  - Bit counter width = clog2(DATA_WIDTH+1).
  - Prescale counter width = clog2(CLKS_PER_BIT+1); wraps to 0 at CLKS_PER_BIT-1.
  - With CLKS_PER_BIT=1 the prescale counter is constant 0 and each state is 1 cycle.
- par_en/par_typ changes during a frame have no effect.
- ser_out holds its last value outside DATA; it is don't-care there, but must be deterministic after reset.

Optional Feature:
- Macro UART_TX_BTB_EN.
- When defined:
  - data_ready is also 1 during the final cycle of STOP.
  - An accept in that cycle goes directly to START with no IDLE cycle between frames; busy stays 1 continuously.
- When undefined:
  - data_ready is 1 only in IDLE.
  - Every frame is followed by at least one IDLE cycle with mux_sel=11.

Test Plan:
- Reset then idle 5 cycles -> mux_sel=11, busy=0, data_ready=1 throughout.
- CLKS_PER_BIT=1, par_en=1, par_typ=0, p_data=8'hA5 -> mux_sel sequence 00, 01×8, 10, 11; ser_out bits 1,0,1,0,0,1,0,1; parity=0; busy high 11 cycles.
- Same stimulus with par_typ=1, p_data=8'h07 -> parity=0; with par_en=0 -> no 10 state, 10-cycle frame.
- CLKS_PER_BIT=4, p_data=8'h01, par_en=0 -> each mux_sel value held 4 cycles, 40-cycle frame, ser_out=1 only in the first data-bit window.
- data_valid held high continuously, p_data=8'h3C then 8'hC3 -> second byte ignored until data_ready:
  - Without UART_TX_BTB_EN: exactly 1 IDLE cycle between frames.
  - With it: START directly follows STOP.
- Assert rst during data bit 3 of 8'hFF -> the next cycle shows mux_sel=11, busy=0, data_ready=1; a new accept then produces a clean full frame.
